// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the multi-channel pulse generator.
//   - per-channel register byte offsets
//   - ctrl / status bit positions
//   - register defaults applied on reset, init and soft reset
//   - channel FSM state type
package pwm_pkg;

  localparam logic [3:0] OFS_CTRL   = 4'd0;
  localparam logic [3:0] OFS_STATUS = 4'd1;
  localparam logic [3:0] OFS_ZERO   = 4'd2;
  localparam logic [3:0] OFS_SIGNAL = 4'd6;
  localparam logic [3:0] OFS_BURST  = 4'd10;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_BURST = 1;
  localparam int CTRL_INV   = 2;
  localparam int CTRL_SRST  = 3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  localparam logic [31:0] DEF_ZERO   = 32'h0000_C345;
  localparam logic [31:0] DEF_SIGNAL = 32'h0000_000A;
  localparam logic [7:0]  DEF_BURST  = 8'd1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one pulse-width channel. Holds its register bank, the shadow
// copies used by the running period, the IDLE/RUN FSM, the period counter
// and the registered output.
//   clk, res_n      clock, async active-low reset
//   init            synchronous restore to defaults
//   sel             this channel is addressed by the bus this cycle
//   ofs             byte offset inside the channel window
//   we / wdata      byte write
//   we32 / wdata32  whole-word write of zero (ofs 2) or signal (ofs 6)
//   rdata           combinational read byte for ofs (registered at top)
//   out, done       PWM output and sticky burst-complete flag
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | not generating; out = invert; waits for enable
// RUN   | counting k over the period, out = active ^ invert
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             init,
  input  logic             sel,
  input  logic [3:0]       ofs,
  input  logic             we,
  input  logic [7:0]       wdata,
  input  logic             we32,
  input  logic [CNT_W-1:0] wdata32,
  output logic [7:0]       rdata,
  output logic             out,
  output logic             done
);

  localparam int NB = CNT_W / 8;
  localparam int KW = CNT_W + 1;
  localparam logic [KW-1:0] K_ONE = KW'(1);

  chan_state_t      state_q, state_d;
  logic             en_q, en_d;
  logic             bmode_q, bmode_d;
  logic             inv_q, inv_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] zero_q, zero_d;
  logic [CNT_W-1:0] signal_q, signal_d;
  logic [7:0]       burst_q, burst_d;
  logic [CNT_W-1:0] zs_q, zs_d;
  logic [CNT_W-1:0] ss_q, ss_d;
  logic [7:0]       bs_q, bs_d;
  logic [KW-1:0]    k_q, k_d;
  logic             out_q, out_d;

  logic [KW-1:0] sum_q, sum_d;
  logic          period_last;
  logic          done_set;
  logic          wr_ctrl, wr_status, srst;

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    bmode_d  = bmode_q;
    inv_d    = inv_q;
    done_d   = done_q;
    zero_d   = zero_q;
    signal_d = signal_q;
    burst_d  = burst_q;
    zs_d     = zs_q;
    ss_d     = ss_q;
    bs_d     = bs_q;
    k_d      = k_q;
    done_set = 1'b0;

    // Period length in CNT_W+1 bits; an all-zero period behaves as P = 1.
    sum_q       = {1'b0, zs_q} + {1'b0, ss_q};
    period_last = (sum_q == '0) ? 1'b1 : (k_q == sum_q - K_ONE);

    wr_ctrl   = we && sel && (ofs == OFS_CTRL);
    wr_status = we && sel && (ofs == OFS_STATUS);
    srst      = wr_ctrl && wdata[CTRL_SRST];

    // FSM (lowest precedence)
    unique case (state_q)
      IDLE: begin
        if (en_q) begin
          state_d = RUN;
          zs_d    = zero_q;
          ss_d    = signal_q;
          bs_d    = (burst_q == 8'd0) ? 8'd1 : burst_q;
          k_d     = '0;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (!en_q) begin
          state_d = IDLE;
          k_d     = '0;
        end else if (period_last) begin
          // Shadows only change here, so a running period is never disturbed.
          k_d  = '0;
          zs_d = zero_q;
          ss_d = signal_q;
          if (bmode_q) begin
            bs_d = bs_q - 8'd1;
            if (bs_q == 8'd1) begin
              done_d   = 1'b1;
              done_set = 1'b1;
              en_d     = 1'b0;
              state_d  = IDLE;
            end
          end
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus writes override the FSM, except that a done being set beats W1C.
    if (wr_ctrl) begin
      en_d    = wdata[CTRL_EN];
      bmode_d = wdata[CTRL_BURST];
      inv_d   = wdata[CTRL_INV];
    end
    if (wr_status && wdata[STAT_DONE] && !done_set) done_d = 1'b0;
    if (we && sel && (ofs == OFS_BURST)) burst_d = wdata;
    for (int b = 0; b < NB; b++) begin
      if (we && sel && (ofs == OFS_ZERO + 4'(b)))   zero_d[8*b +: 8]   = wdata;
      if (we && sel && (ofs == OFS_SIGNAL + 4'(b))) signal_d[8*b +: 8] = wdata;
    end
    // Word write lands after the byte write so it wins on any overlap.
    if (we32 && sel && (ofs == OFS_ZERO))   zero_d   = wdata32;
    if (we32 && sel && (ofs == OFS_SIGNAL)) signal_d = wdata32;

    if (init || srst) begin
      state_d  = IDLE;
      en_d     = 1'b0;
      bmode_d  = 1'b0;
      inv_d    = 1'b0;
      done_d   = 1'b0;
      zero_d   = DEF_ZERO[CNT_W-1:0];
      signal_d = DEF_SIGNAL[CNT_W-1:0];
      burst_d  = DEF_BURST;
      zs_d     = '0;
      ss_d     = '0;
      bs_d     = '0;
      k_d      = '0;
    end

    // out is computed from the next counter/shadow values so the flop shows
    // the phase of the cycle that follows the edge.
    sum_d = {1'b0, zs_d} + {1'b0, ss_d};
    out_d = ((state_d == RUN) && (k_d >= {1'b0, zs_d}) && (k_d < sum_d)) ^ inv_q;
    if (init || srst) out_d = 1'b0;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      bmode_q  <= 1'b0;
      inv_q    <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= DEF_ZERO[CNT_W-1:0];
      signal_q <= DEF_SIGNAL[CNT_W-1:0];
      burst_q  <= DEF_BURST;
      zs_q     <= '0;
      ss_q     <= '0;
      bs_q     <= '0;
      k_q      <= '0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      bmode_q  <= bmode_d;
      inv_q    <= inv_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      signal_q <= signal_d;
      burst_q  <= burst_d;
      zs_q     <= zs_d;
      ss_q     <= ss_d;
      bs_q     <= bs_d;
      k_q      <= k_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    rdata = 8'h00;
    unique case (ofs)
      OFS_CTRL:   rdata = {5'b0, inv_q, bmode_q, en_q};
      OFS_STATUS: rdata = {6'b0, done_q, (state_q == RUN)};
      OFS_BURST:  rdata = burst_q;
      default:    rdata = 8'h00;
    endcase
    for (int b = 0; b < NB; b++) begin
      if (ofs == OFS_ZERO + 4'(b))   rdata = zero_q[8*b +: 8];
      if (ofs == OFS_SIGNAL + 4'(b)) rdata = signal_q[8*b +: 8];
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: CH-channel pulse-width generator on the 8-bit register bus.
//   clk, res_n           clock, async active-low reset
//   addr                 byte address; channel c at BASE+16*c .. +15
//   data_in, we          byte write
//   we32, data_in32      word write (truncated to CNT_W)
//   init                 synchronous restore of all channels
//   data_out             registered read byte, held on unmapped addresses
//   out[CH], done[CH]    per-channel PWM output and burst-complete flag
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int         CH    = 4,
  parameter int         CNT_W = 32,
  parameter logic [7:0] BASE  = 8'h40
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic [7:0]    addr,
  input  logic [7:0]    data_in,
  output logic [7:0]    data_out,
  input  logic          we,
  input  logic          init,
  input  logic          we32,
  input  logic [31:0]   data_in32,
  output logic [CH-1:0] out,
  output logic [CH-1:0] done
);

  logic [8:0]    rel;
  logic          hit;
  logic [CH-1:0] sel;
  logic [7:0]    rd_data [CH];
  logic [7:0]    data_out_q, data_out_d;

  // Decode in 9 bits so a window reaching past 8'hFF does not wrap.
  always_comb begin
    rel = {1'b0, addr} - {1'b0, BASE};
    hit = (addr >= BASE) && (rel < 9'(16 * CH));
    sel = '0;
    for (int c = 0; c < CH; c++) begin
      if (hit && (rel[8:4] == 5'(c))) sel[c] = 1'b1;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    pwm_chan #(.CNT_W(CNT_W)) u_chan (
      .clk     (clk),
      .res_n   (res_n),
      .init    (init),
      .sel     (sel[c]),
      .ofs     (rel[3:0]),
      .we      (we),
      .wdata   (data_in),
      .we32    (we32),
      .wdata32 (data_in32[CNT_W-1:0]),
      .rdata   (rd_data[c]),
      .out     (out[c]),
      .done    (done[c])
    );
  end

  always_comb begin
    data_out_d = data_out_q;
    for (int c = 0; c < CH; c++) begin
      if (sel[c]) data_out_d = rd_data[c];
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) data_out_q <= 8'h00;
    else        data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       we = 1'b0;
  logic       init = 1'b0;
  logic       we32 = 1'b0;
  logic [31:0] data_in32 = 32'h0;
  logic [3:0] out;
  logic [3:0] done;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pwm_multi #(.CH(4), .CNT_W(32), .BASE(8'h40)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .we        (we),
    .init      (init),
    .we32      (we32),
    .data_in32 (data_in32),
    .out       (out),
    .done      (done)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    addr = a;
    @(posedge clk); #1;
    v = data_out;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    #12;
    n_cmp++; if (out !== 4'h0) begin n_mis++; $display("FAIL rst_out got %h want 0", out); end
    n_cmp++; if (done !== 4'h0) begin n_mis++; $display("FAIL rst_done got %h want 0", done); end
    n_cmp++; if (data_out !== 8'h00) begin n_mis++; $display("FAIL rst_dout got %h want 00", data_out); end
    #11 res_n = 1'b1;
    tick(1);
    rd(8'h42, v);
    n_cmp++; if (v !== 8'h45) begin n_mis++; $display("FAIL rst_zero_b0 got %h want 45", v); end
    rd(8'h43, v);
    n_cmp++; if (v !== 8'hC3) begin n_mis++; $display("FAIL rst_zero_b1 got %h want c3", v); end
    rd(8'h46, v);
    n_cmp++; if (v !== 8'h0A) begin n_mis++; $display("FAIL rst_signal_b0 got %h want 0a", v); end
    rd(8'h4A, v);
    n_cmp++; if (v !== 8'h01) begin n_mis++; $display("FAIL rst_burst got %h want 01", v); end
  endtask

  task automatic test_period;
    logic e;
    wr(8'h52, 8'd3); wr(8'h53, 8'd0); wr(8'h56, 8'd2);
    wr(8'h50, 8'h01);
    for (int j = 1; j <= 15; j++) begin
      tick(1);
      e = (((j - 1) % 5) >= 3);
      n_cmp++; if (out[1] !== e) begin n_mis++; $display("FAIL period_ch1 j=%0d got %b want %b", j, out[1], e); end
    end
    wr(8'h50, 8'h00);
    tick(1);
    n_cmp++; if (out[1] !== 1'b0) begin n_mis++; $display("FAIL period_disable got %b want 0", out[1]); end
  endtask

  task automatic test_glitch_free;
    logic e;
    wr(8'h42, 8'd4); wr(8'h43, 8'd0); wr(8'h46, 8'd4);
    wr(8'h40, 8'h01);
    for (int j = 1; j <= 18; j++) begin
      if (j == 7) begin addr = 8'h46; data_in = 8'd1; we = 1'b1; end
      @(posedge clk); #1;
      we = 1'b0;
      e = ((j >= 5) && (j <= 8)) || (j == 13) || (j == 18);
      n_cmp++; if (out[0] !== e) begin n_mis++; $display("FAIL glitch_ch0 j=%0d got %b want %b", j, out[0], e); end
    end
    wr(8'h40, 8'h00);
  endtask

  task automatic test_burst;
    logic [7:0] v;
    logic e;
    wr(8'h62, 8'd1); wr(8'h63, 8'd0); wr(8'h66, 8'd1); wr(8'h6A, 8'd3);
    wr(8'h60, 8'h03);
    for (int j = 1; j <= 10; j++) begin
      tick(1);
      e = (j == 2) || (j == 4) || (j == 6);
      n_cmp++; if (out[2] !== e) begin n_mis++; $display("FAIL burst_out j=%0d got %b want %b", j, out[2], e); end
      e = (j >= 7);
      n_cmp++; if (done[2] !== e) begin n_mis++; $display("FAIL burst_done j=%0d got %b want %b", j, done[2], e); end
    end
    rd(8'h61, v);
    n_cmp++; if (v !== 8'h02) begin n_mis++; $display("FAIL burst_status got %h want 02", v); end
    rd(8'h60, v);
    n_cmp++; if (v !== 8'h02) begin n_mis++; $display("FAIL burst_ctrl got %h want 02", v); end
    wr(8'h61, 8'h02);
    n_cmp++; if (done[2] !== 1'b0) begin n_mis++; $display("FAIL burst_w1c got %b want 0", done[2]); end
    rd(8'h61, v);
    n_cmp++; if (v !== 8'h00) begin n_mis++; $display("FAIL burst_status_clr got %h want 00", v); end
  endtask

  task automatic test_ratios;
    logic [7:0] v;
    wr(8'h72, 8'd0); wr(8'h73, 8'd0); wr(8'h76, 8'd5);
    wr(8'h70, 8'h01);
    for (int j = 1; j <= 12; j++) begin
      tick(1);
      n_cmp++; if (out[3] !== 1'b1) begin n_mis++; $display("FAIL ratio_z0 j=%0d got %b want 1", j, out[3]); end
    end
    rd(8'h71, v);
    n_cmp++; if (v !== 8'h01) begin n_mis++; $display("FAIL ratio_busy got %h want 01", v); end
    wr(8'h70, 8'h00); wr(8'h72, 8'd3); wr(8'h76, 8'd0);
    wr(8'h70, 8'h01);
    for (int j = 1; j <= 10; j++) begin
      tick(1);
      n_cmp++; if (out[3] !== 1'b0) begin n_mis++; $display("FAIL ratio_s0 j=%0d got %b want 0", j, out[3]); end
    end
    wr(8'h70, 8'h00); wr(8'h72, 8'd0);
    wr(8'h70, 8'h05);
    for (int j = 1; j <= 10; j++) begin
      tick(1);
      n_cmp++; if (out[3] !== 1'b1) begin n_mis++; $display("FAIL ratio_inv00 j=%0d got %b want 1", j, out[3]); end
    end
  endtask

  task automatic test_abort_reset;
    logic [7:0] v;
    n_cmp++; if (out[3] !== 1'b1) begin n_mis++; $display("FAIL areset_pre got %b want 1", out[3]); end
    #3 res_n = 1'b0;
    #1;
    n_cmp++; if (out !== 4'h0) begin n_mis++; $display("FAIL areset_out got %h want 0", out); end
    #2 res_n = 1'b1;
    tick(1);
    rd(8'h70, v);
    n_cmp++; if (v !== 8'h00) begin n_mis++; $display("FAIL areset_ctrl got %h want 00", v); end
  endtask

  task automatic test_init;
    logic [7:0] v;
    wr(8'h52, 8'd3); wr(8'h53, 8'd0); wr(8'h56, 8'd2);
    wr(8'h50, 8'h01);
    tick(4);
    n_cmp++; if (out[1] !== 1'b1) begin n_mis++; $display("FAIL init_pre got %b want 1", out[1]); end
    init = 1'b1;
    tick(1);
    init = 1'b0;
    n_cmp++; if (out[1] !== 1'b0) begin n_mis++; $display("FAIL init_out got %b want 0", out[1]); end
    rd(8'h50, v);
    n_cmp++; if (v !== 8'h00) begin n_mis++; $display("FAIL init_ctrl got %h want 00", v); end
    rd(8'h51, v);
    n_cmp++; if (v !== 8'h00) begin n_mis++; $display("FAIL init_status got %h want 00", v); end
    rd(8'h52, v);
    n_cmp++; if (v !== 8'h45) begin n_mis++; $display("FAIL init_zero got %h want 45", v); end
    rd(8'h56, v);
    n_cmp++; if (v !== 8'h0A) begin n_mis++; $display("FAIL init_signal got %h want 0a", v); end
    tick(6);
    n_cmp++; if (out[1] !== 1'b0) begin n_mis++; $display("FAIL init_idle got %b want 0", out[1]); end
  endtask

  task automatic test_we32;
    logic [7:0] v;
    addr = 8'h42; data_in = 8'h11; we = 1'b1; we32 = 1'b1; data_in32 = 32'hA1B2_C3D4;
    tick(1);
    we = 1'b0; we32 = 1'b0;
    rd(8'h42, v);
    n_cmp++; if (v !== 8'hD4) begin n_mis++; $display("FAIL we32_b0 got %h want d4", v); end
    rd(8'h43, v);
    n_cmp++; if (v !== 8'hC3) begin n_mis++; $display("FAIL we32_b1 got %h want c3", v); end
    rd(8'h44, v);
    n_cmp++; if (v !== 8'hB2) begin n_mis++; $display("FAIL we32_b2 got %h want b2", v); end
    rd(8'h45, v);
    n_cmp++; if (v !== 8'hA1) begin n_mis++; $display("FAIL we32_b3 got %h want a1", v); end
    addr = 8'h46; we32 = 1'b1; data_in32 = 32'h0000_0007;
    tick(1);
    we32 = 1'b0;
    rd(8'h46, v);
    n_cmp++; if (v !== 8'h07) begin n_mis++; $display("FAIL we32_sig got %h want 07", v); end
    wr(8'h40, 8'h09);
    rd(8'h42, v);
    n_cmp++; if (v !== 8'h45) begin n_mis++; $display("FAIL srst_zero got %h want 45", v); end
    rd(8'h40, v);
    n_cmp++; if (v !== 8'h00) begin n_mis++; $display("FAIL srst_ctrl got %h want 00", v); end
    rd(8'h4B, v);
    n_cmp++; if (v !== 8'h00) begin n_mis++; $display("FAIL reserved got %h want 00", v); end
    rd(8'h43, v);
    rd(8'h10, v);
    n_cmp++; if (v !== 8'hC3) begin n_mis++; $display("FAIL unmapped_lo got %h want c3", v); end
    rd(8'h80, v);
    n_cmp++; if (v !== 8'hC3) begin n_mis++; $display("FAIL unmapped_hi got %h want c3", v); end
  endtask

  initial begin
    test_reset();
    test_period();
    test_glitch_free();
    test_burst();
    test_ratios();
    test_abort_reset();
    test_init();
    test_we32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised pulse-width generator on the 8-bit register bus. Each channel produces a repeating low/high waveform set by per-channel low-count and high-count registers, with glitch-free updates, polarity control and a finite-burst mode. It replaces single-channel PWM instances in the scan-control fabric, e.g. for LED/laser trigger pulses and gate windows.

## Interface
- CH, 4, number of channels (1..12)
- CNT_W, 32, counter/register width in bits (8, 16, 24 or 32)
- BASE, 8'h40, bus address of channel 0; channel c occupies BASE+16*c .. BASE+16*c+15
- clk  in  1  system clock
- res_n  in  1  reset; one clock; reset is asynchronous and active-low
- addr  in  8  register address
- data_in  in  8  byte write data
- data_out  out  8  registered read data
- we  in  1  byte write strobe
- init  in  1  synchronous restore of all channels to defaults
- we32  in  1  word write strobe
- data_in32  in  32  word write data, truncated to CNT_W
- out  out  CH  PWM outputs
- done  out  CH  sticky burst-complete flags (mirror of status[1])

## Operation
- Per-channel byte offsets:
  - 0 ctrl: [0] enable, [1] burst mode, [2] invert, [3] soft reset (self-clearing, reads 0)
  - 1 status: [0] busy (RO), [1] done (write 1 to clear)
  - 2..5 zero (low count, little-endian)
  - 6..9 signal (high count)
  - 10 burst count
  - 11..15 reserved, read 0
- Bytes at or above CNT_W/8 within zero/signal read 0; writes to them are ignored.
- we32 with addr = channel base+2 writes the whole zero word; with addr = base+6, the whole signal word. If we and we32 hit the same byte in one cycle, we32 wins.
- Defaults on reset, init or soft reset: ctrl 0, status 0, zero 16'hC345, signal 8'h0A, burst 1, channel in IDLE.
- Channel FSM states are IDLE and RUN.
- IDLE -> RUN when enable = 1. On that transition:
  - copy zero/signal/burst into shadow registers Zs/Ss/Bs (burst 0 is treated as 1)
  - clear period counter k
  - clear done
- In RUN:
  - k counts 0 .. P-1, where P = max(1, Zs+Ss) computed in CNT_W+1 bits
  - active = (k >= Zs) && (k < Zs+Ss)
  - out = active ^ invert
- Period end (k = P-1):
  - reload Zs/Ss from the live registers, so writes during a period never alter it
  - in burst mode, decrement Bs; if Bs reaches 0, set done, clear enable and go to IDLE
- Register edge cases:
  - Zs = 0: 100 % duty
  - Ss = 0: 0 % duty
  - both 0: out stays inactive, P = 1
- enable cleared mid-period: next edge goes to IDLE with out = invert and k = 0.
- busy = (state == RUN).
- Reads: data_out <= selected byte on every edge; unmapped addresses leave data_out unchanged.

## Timing
- Reset values:
  - out = 0, done = 0, data_out = 0
  - all registers at their defaults
- Read latency is 1 clock: addr sampled at edge E, data_out valid after E.
- A ctrl write with enable = 1, captured at edge E, enters RUN at edge E+1 (k = 0 during the following cycle). For Z, S:
  - out goes active at edge E+1+Z
  - out goes inactive at edge E+1+Z+S
  - the pattern repeats every Z+S cycles
- out is registered and glitch-free; polarity changes apply at the next edge.
- done rises on the same edge that out returns inactive after the last burst pulse.
- A W1C clear of done in the same cycle as done being set: set wins.
- Order of precedence, highest first: res_n, then init, then soft reset, then bus writes, then FSM.

## Structure
- Package pwm_pkg holds:
  - offset localparams (OFS_CTRL … OFS_BURST)
  - ctrl/status bit indices
  - default values (DEF_ZERO, DEF_SIGNAL)
  - chan_state_t enum {IDLE, RUN}
- Sub-module pwm_chan (parameter CNT_W): registers, shadows, FSM, counter, one out/done bit.
- Top pwm_multi holds address decode, the CH-way generate of pwm_chan, and the read mux.

## Test plan
- Reset, then read ch0 offsets 2..3 and 6 -> 8'h45, 8'hC3, 8'h0A; out = 0, done = 0.
- Ch1: zero = 3, signal = 2, enable -> out high at edges E+4..E+5, low at E+6..E+8, period 5, repeats.
- Ch0 running with Z=4, S=4; write signal = 1 mid-period -> current period keeps 4 high cycles, next period has 1.
- Ch2 burst mode with burst = 3, Z=1, S=1 -> exactly 3 pulses, then done = 1, busy = 0, enable reads 0; writing status = 2 clears done.
- Edge ratios: Z=0,S=5 -> out constantly 1; S=0 -> constantly 0; invert = 1 with both 0 -> out constantly 1.
- Abort paths:
  - res_n low mid-high-pulse -> out 0 asynchronously
  - init mid-run -> defaults and IDLE on the next edge
  - same-cycle we32 and byte write to zero -> we32 value stored
